// File: rtl/led_pulse_stretcher_pkg.sv
// Shared types and defaults for the LED pulse stretcher: channel state encoding,
// default timing constants and a helper sizing the hold/gap timer.
package led_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_HOLD_TIME = 150_000;
  localparam int unsigned DEFAULT_GAP_TIME  = 150_000;

  // Number of bits needed to represent the value 'cycles'.
  function automatic int unsigned cnt_w_for(input int unsigned cycles);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((cycles >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// Event/indicator bundle between the event sources and the pulse stretcher.
interface led_pulse_stretcher_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] event_in;
  logic            clr_ovf;
  logic [N_CH-1:0] led_out;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] overflow;

  modport master (
    output event_in,
    output clr_ovf,
    input  led_out,
    input  busy,
    input  overflow
  );

  modport slave (
    input  event_in,
    input  clr_ovf,
    output led_out,
    output busy,
    output overflow
  );

endinterface

// File: rtl/led_pulse_stretcher_ch.sv
// Single channel: stretches event strobes into HOLD_TIME-high pulses separated by
// at least GAP_TIME low cycles, queueing events that arrive while busy.
module led_pulse_ch
  import led_pulse_pkg::*;
#(
  parameter int HOLD_TIME = DEFAULT_HOLD_TIME,
  parameter int GAP_TIME  = DEFAULT_GAP_TIME,
  parameter int CNT_W     = 26,
  parameter int PEND_W    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic event_in,
  input  logic clr_ovf,
  output logic led_out,
  output logic busy,
  output logic overflow
);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_TIME - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_TIME - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_set;
  logic              led_q;
  logic              gap_final;

  assign gap_final = (state_q == GAP) && (timer_q == GAP_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      // A fresh overflow in the same cycle as a clear keeps the flag set.
      ovf_q   <= ovf_set | (ovf_q & ~clr_ovf);
      led_q   <= (state_d == HOLD);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    pend_d  = pend_q;
    ovf_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (event_in) state_d = HOLD;
      end
      HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d = GAP;
          timer_d = '0;
        end
      end
      GAP: begin
        if (gap_final) begin
          timer_d = '0;
          if (pend_q != '0) begin
            // A coincident strobe replaces the replayed one, so pending is unchanged.
            state_d = HOLD;
            if (!event_in) pend_d = pend_q - 1'b1;
          end else begin
            state_d = event_in ? HOLD : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (event_in && (state_q != IDLE) && !gap_final) begin
      if (pend_q == PEND_MAX) ovf_set = 1'b1;
      else                    pend_d  = pend_q + 1'b1;
    end
  end

  always_comb begin
    led_out  = led_q;
    busy     = (state_q != IDLE);
    overflow = ovf_q;
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// N_CH independent pulse-stretcher channels; outputs are concatenated per channel
// and the overflow clear is shared by all channels.
module led_pulse_stretcher
  import led_pulse_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int HOLD_TIME = DEFAULT_HOLD_TIME,
  parameter int GAP_TIME  = DEFAULT_GAP_TIME,
  parameter int CNT_W     = 26,
  parameter int PEND_W    = 3
) (
  input logic                clk,
  input logic                rst_n,
  led_pulse_stretcher_if.slave bus
);

  logic [N_CH-1:0] led_vec;
  logic [N_CH-1:0] busy_vec;
  logic [N_CH-1:0] ovf_vec;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    led_pulse_ch #(
      .HOLD_TIME (HOLD_TIME),
      .GAP_TIME  (GAP_TIME),
      .CNT_W     (CNT_W),
      .PEND_W    (PEND_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .event_in (bus.event_in[ch]),
      .clr_ovf  (bus.clr_ovf),
      .led_out  (led_vec[ch]),
      .busy     (busy_vec[ch]),
      .overflow (ovf_vec[ch])
    );
  end

  assign bus.led_out  = led_vec;
  assign bus.busy     = busy_vec;
  assign bus.overflow = ovf_vec;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with HOLD_TIME=4, GAP_TIME=2, PEND_W=2.
module tb_led_pulse_stretcher;

  typedef struct {
    logic       rst_n;
    logic [3:0] ev;
    logic       clr;
    logic [3:0] led;
    logic [3:0] busy;
    logic [3:0] ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];
  int   pulses, highs;
  logic prev_led;
  logic done;

  always #5 clk = ~clk;

  led_pulse_stretcher_if #(.N_CH(4)) bus ();

  led_pulse_stretcher #(
    .N_CH      (4),
    .HOLD_TIME (4),
    .GAP_TIME  (2),
    .CNT_W     (4),
    .PEND_W    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for one edge, then sample just after it.
  task automatic step(input logic [3:0] ev, input logic clr, input logic rst);
    bus.event_in = ev;
    bus.clr_ovf  = clr;
    rst_n        = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int n, input logic r, input logic [3:0] ev, input logic clr,
                     input logic [3:0] led, input logic [3:0] busy, input logic [3:0] ovf);
    vec_t v;
    v.rst_n = r; v.ev = ev; v.clr = clr; v.led = led; v.busy = busy; v.ovf = ovf;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic track2();
    if (bus.led_out[2]) highs++;
    if (bus.led_out[2] && !prev_led) pulses++;
    prev_led = bus.led_out[2];
  endtask

  initial begin
    bus.event_in = '0;
    bus.clr_ovf  = 1'b0;
    rst_n        = 1'b0;

    // Reset with events pending on every channel, then first cycle after release.
    add(3, 0, 4'hF, 0, 4'h0, 4'h0, 4'h0);
    add(1, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    // Single strobe on ch0: 4 high, 2 low, then idle.
    add(1, 1, 4'h1, 0, 4'h1, 4'h1, 4'h0);
    add(3, 1, 4'h0, 0, 4'h1, 4'h1, 4'h0);
    add(2, 1, 4'h0, 0, 4'h0, 4'h1, 4'h0);
    add(2, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    // ch1: strobe plus two queued strobes -> three back-to-back pulses.
    add(3, 1, 4'h2, 0, 4'h2, 4'h2, 4'h0);
    add(1, 1, 4'h0, 0, 4'h2, 4'h2, 4'h0);
    add(2, 1, 4'h0, 0, 4'h0, 4'h2, 4'h0);
    add(4, 1, 4'h0, 0, 4'h2, 4'h2, 4'h0);
    add(2, 1, 4'h0, 0, 4'h0, 4'h2, 4'h0);
    add(4, 1, 4'h0, 0, 4'h2, 4'h2, 4'h0);
    add(2, 1, 4'h0, 0, 4'h0, 4'h2, 4'h0);
    add(2, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    // ch3: strobe on the final gap cycle restarts HOLD with no idle cycle.
    add(1, 1, 4'h8, 0, 4'h8, 4'h8, 4'h0);
    add(3, 1, 4'h0, 0, 4'h8, 4'h8, 4'h0);
    add(2, 1, 4'h0, 0, 4'h0, 4'h8, 4'h0);
    add(1, 1, 4'h8, 0, 4'h8, 4'h8, 4'h0);
    add(3, 1, 4'h0, 0, 4'h8, 4'h8, 4'h0);
    add(2, 1, 4'h0, 0, 4'h0, 4'h8, 4'h0);
    add(2, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ev, tbl[i].clr, tbl[i].rst_n);
      check($sformatf("vec%0d_led", i),  bus.led_out,  tbl[i].led);
      check($sformatf("vec%0d_busy", i), bus.busy,     tbl[i].busy);
      check($sformatf("vec%0d_ovf", i),  bus.overflow, tbl[i].ovf);
    end

    // ch2: pending saturates at 3, the fourth queued strobe is dropped.
    pulses = 0; highs = 0; prev_led = 1'b0;
    step(4'h4, 0, 1); track2();
    for (int i = 0; i < 3; i++) begin step(4'h4, 0, 1); track2(); end
    check("t4_ovf_before", bus.overflow, 4'h0);
    step(4'h4, 0, 1); track2();
    check("t4_ovf_set", bus.overflow, 4'h4);
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step(4'h0, 0, 1); track2();
      done = !bus.busy[2];
    end
    check_int("t4_idle_reached", int'(done), 1);
    check_int("t4_pulses", pulses, 4);
    check_int("t4_high_cycles", highs, 16);
    check("t4_ovf_sticky", bus.overflow, 4'h4);
    step(4'h0, 1, 1);
    check("t4_ovf_cleared", bus.overflow, 4'h0);

    // Clear coincident with an overflowing strobe: set wins.
    step(4'h4, 0, 1);
    for (int i = 0; i < 3; i++) step(4'h4, 0, 1);
    step(4'h4, 1, 1);
    check("t4_set_wins", bus.overflow, 4'h4);
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step(4'h0, 0, 1);
      done = !bus.busy[2];
    end
    check_int("t4_idle_reached2", int'(done), 1);
    step(4'h0, 1, 1);
    check("t4_ovf_cleared2", bus.overflow, 4'h0);

    // ch0+ch3 together, extra queued strobe, then reset mid-HOLD.
    step(4'h9, 0, 1);
    check("t6_led_aligned0", bus.led_out, 4'h9);
    step(4'h9, 0, 1);
    check("t6_led_aligned1", bus.led_out, 4'h9);
    check("t6_busy_aligned", bus.busy, 4'h9);
    step(4'h0, 0, 0);
    check("t6_rst_led", bus.led_out, 4'h0);
    check("t6_rst_busy", bus.busy, 4'h0);
    check("t6_rst_ovf", bus.overflow, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(4'h0, 0, 1);
      check($sformatf("t6_no_replay%0d_led", i), bus.led_out, 4'h0);
      check($sformatf("t6_no_replay%0d_busy", i), bus.busy, 4'h0);
    end
    step(4'h1, 0, 1);
    check("t6_post_led0", bus.led_out, 4'h1);
    for (int i = 1; i < 8; i++) begin
      step(4'h0, 0, 1);
      check($sformatf("t6_post_led%0d", i), bus.led_out, (i < 4) ? 4'h1 : 4'h0);
      check($sformatf("t6_post_busy%0d", i), bus.busy, (i < 6) ? 4'h1 : 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
